// File: rtl/sid_write_arbiter.sv
// Two-requester round-robin write arbiter driving the SID register port
// with a timed setup / strobe / hold sequence and a one-cycle completion ack.
module sid_write_arbiter #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 1,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] addr0,
  input  logic [2:0] addr1,
  input  logic [1:0] voice0,
  input  logic [1:0] voice1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic [2:0] bus_addr,
  output logic [1:0] bus_voice,
  output logic [7:0] bus_data,
  output logic       bus_we,
  output logic       busy,
  output logic       grant_id
);

  localparam int unsigned PHASE_W     = 4;
  localparam logic [PHASE_W-1:0] SETUP_LAST  = PHASE_W'(SETUP_CYC - 1);
  localparam logic [PHASE_W-1:0] STROBE_LAST = PHASE_W'(STROBE_CYC - 1);
  localparam logic [PHASE_W-1:0] HOLD_LAST   = PHASE_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t             state;
  logic [PHASE_W-1:0] phase;
  logic               rr_next;   // requester preferred on the next contention
  logic               pick1_c;

  // Requester 1 wins when it asks alone, or when both ask and it is its turn.
  assign pick1_c = req1 & (~req0 | rr_next);

  // Write sequencer; every output is a register so bus_we and the acks are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      rr_next   <= 1'b0;
      grant_id  <= 1'b0;
      bus_addr  <= '0;
      bus_voice <= '0;
      bus_data  <= '0;
      bus_we    <= 1'b0;
      busy      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant_id  <= pick1_c;
            rr_next   <= ~pick1_c;
            bus_addr  <= pick1_c ? addr1  : addr0;
            bus_voice <= pick1_c ? voice1 : voice0;
            bus_data  <= pick1_c ? data1  : data0;
            busy      <= 1'b1;
            phase     <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (phase == SETUP_LAST) begin
            phase  <= '0;
            bus_we <= 1'b1;
            state  <= STROBE;
          end else begin
            phase <= phase + PHASE_W'(1);
          end
        end
        STROBE: begin
          if (phase == STROBE_LAST) begin
            phase  <= '0;
            bus_we <= 1'b0;
            state  <= HOLD;
          end else begin
            phase <= phase + PHASE_W'(1);
          end
        end
        HOLD: begin
          if (phase == HOLD_LAST) begin
            phase <= '0;
            ack0  <= ~grant_id;
            ack1  <= grant_id;
            state <= DONE;
          end else begin
            phase <= phase + PHASE_W'(1);
          end
        end
        DONE: begin
          // No arbitration here; a held request is picked up in the following IDLE cycle.
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          phase  <= '0;
          bus_we <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sid_write_arbiter.sv
// Directed bench for sid_write_arbiter: default-timing instance plus a
// 2/3/2 timing instance, with a negedge bus monitor.
module tb_sid_write_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [2:0] addr0, addr1;
  logic [1:0] voice0, voice1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, bus_we, busy, grant_id;
  logic [2:0] bus_addr;
  logic [1:0] bus_voice;
  logic [7:0] bus_data;

  logic       b_req0, b_req1;
  logic [2:0] b_addr0, b_addr1;
  logic [1:0] b_voice0, b_voice1;
  logic [7:0] b_data0, b_data1;
  logic       b_ack0, b_ack1, b_bus_we, b_busy, b_grant_id;
  logic [2:0] b_bus_addr;
  logic [1:0] b_bus_voice;
  logic [7:0] b_bus_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0] log_q[$];
  int          we_cycles;
  logic        we_prev = 1'b0;

  sid_write_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .voice0(voice0), .voice1(voice1),
    .data0(data0), .data1(data1), .ack0(ack0), .ack1(ack1),
    .bus_addr(bus_addr), .bus_voice(bus_voice), .bus_data(bus_data),
    .bus_we(bus_we), .busy(busy), .grant_id(grant_id)
  );

  sid_write_arbiter #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut_b (
    .clk(clk), .rst(rst), .req0(b_req0), .req1(b_req1),
    .addr0(b_addr0), .addr1(b_addr1), .voice0(b_voice0), .voice1(b_voice1),
    .data0(b_data0), .data1(b_data1), .ack0(b_ack0), .ack1(b_ack1),
    .bus_addr(b_bus_addr), .bus_voice(b_bus_voice), .bus_data(b_bus_data),
    .bus_we(b_bus_we), .busy(b_busy), .grant_id(b_grant_id)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus monitor: records each strobe's payload, counts strobe cycles, checks ack exclusivity.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
      if (bus_we) begin
        we_cycles++;
        if (!we_prev) log_q.push_back({bus_voice, bus_addr, bus_data});
      end
    end
    we_prev = bus_we & ~rst;
  end

  initial begin
    logic [17:0] we_exp, busy_exp, ack_exp;
    logic [12:0] entry;
    logic [3:0]  grant_exp;

    rst = 1'b1;
    {req0, req1, b_req0, b_req1} = '0;
    {addr0, addr1, b_addr0, b_addr1} = '0;
    {voice0, voice1, b_voice0, b_voice1} = '0;
    {data0, data1, b_data0, b_data1} = '0;
    we_cycles = 0;

    // Reset state
    tick(); tick();
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", 32'({ack0, ack1}), 32'd0);
    chk("rst_fields", 32'({bus_voice, bus_addr, bus_data}), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    rst = 1'b0;
    tick();

    // Single req0 write, default timing
    req0 = 1'b1; addr0 = 3'd6; voice0 = 2'd0; data0 = 8'h21;
    tick();
    chk("w1_setup_we", 32'(bus_we), 32'd0);
    chk("w1_setup_busy", 32'(busy), 32'd1);
    chk("w1_setup_fields", 32'({bus_voice, bus_addr, bus_data}), 32'h0621);
    chk("w1_grant", 32'(grant_id), 32'd0);
    tick();
    chk("w1_strobe_we", 32'(bus_we), 32'd1);
    chk("w1_strobe_fields", 32'({bus_voice, bus_addr, bus_data}), 32'h0621);
    tick();
    chk("w1_hold_we", 32'(bus_we), 32'd0);
    chk("w1_hold_ack0", 32'(ack0), 32'd0);
    tick();
    chk("w1_done_acks", 32'({ack0, ack1}), 32'b10);
    chk("w1_done_fields", 32'({bus_voice, bus_addr, bus_data}), 32'h0621);
    req0 = 1'b0;
    tick();
    chk("w1_idle_busy", 32'(busy), 32'd0);
    chk("w1_idle_ack0", 32'(ack0), 32'd0);
    chk("w1_idle_retain", 32'({bus_voice, bus_addr, bus_data}), 32'h0621);
    tick();

    // Round-robin contention from a fresh reset: order 0,1,0,1
    rst = 1'b1; tick(); rst = 1'b0;
    req0 = 1'b1; addr0 = 3'd1; voice0 = 2'd1; data0 = 8'h11;
    req1 = 1'b1; addr1 = 3'd2; voice1 = 2'd2; data1 = 8'h22;
    grant_exp = 4'b1010;
    for (int w = 0; w < 4; w++) begin
      tick();
      chk("rr_grant", 32'(grant_id), 32'(grant_exp[w]));
      tick();
      chk("rr_strobe_we", 32'(bus_we), 32'd1);
      chk("rr_payload", 32'({bus_voice, bus_addr, bus_data}),
          grant_exp[w] ? 32'h1222 : 32'h0911);
      tick();
      tick();
      chk("rr_acks", 32'({ack0, ack1}), grant_exp[w] ? 32'b01 : 32'b10);
      if (w == 3) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
    end
    tick();
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // Requester input change after grant is ignored
    req0 = 1'b1; addr0 = 3'd3; voice0 = 2'd3; data0 = 8'h0F;
    tick();
    tick();
    data0 = 8'hFF; addr0 = 3'd7;
    tick();
    chk("chg_hold_data", 32'(bus_data), 32'h0F);
    tick();
    chk("chg_done_fields", 32'({bus_voice, bus_addr, bus_data}), 32'h1B0F);
    chk("chg_done_ack0", 32'(ack0), 32'd1);
    req0 = 1'b0;
    tick(); tick();

    // Reset during STROBE aborts the write; held req0 is then written in full
    req0 = 1'b1; addr0 = 3'd5; voice0 = 2'd1; data0 = 8'h5A;
    tick();
    tick();
    chk("abort_strobe_we", 32'(bus_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_we_async", 32'(bus_we), 32'd0);
    chk("abort_busy_async", 32'(busy), 32'd0);
    tick();
    chk("abort_no_ack", 32'({ack0, ack1}), 32'd0);
    rst = 1'b0;
    tick();
    chk("abort_regrant_busy", 32'(busy), 32'd1);
    chk("abort_regrant_fields", 32'({bus_voice, bus_addr, bus_data}), 32'h0D5A);
    tick();
    chk("abort_re_we", 32'(bus_we), 32'd1);
    tick();
    chk("abort_re_hold_ack", 32'({ack0, ack1}), 32'd0);
    tick();
    chk("abort_re_ack0", 32'({ack0, ack1}), 32'b10);
    req0 = 1'b0;
    tick(); tick();

    // Eleven back-to-back req1 writes: voice 0 regs 0..6, filter bank regs 0..3
    log_q.delete();
    we_cycles = 0;
    req1 = 1'b1;
    for (int i = 0; i < 11; i++) begin
      addr1  = (i < 7) ? 3'(i) : 3'(i - 7);
      voice1 = (i < 7) ? 2'd0 : 2'd3;
      data1  = 8'(8'h30 + i * 5);
      tick();
      chk("b2b_grant", 32'(grant_id), 32'd1);
      tick(); tick(); tick();
      chk("b2b_ack1", 32'({ack0, ack1}), 32'b01);
      if (i == 10) req1 = 1'b0;
      tick();
    end
    tick(); tick();
    chk("b2b_count", 32'(log_q.size()), 32'd11);
    chk("b2b_we_cycles", 32'(we_cycles), 32'd11);
    for (int i = 0; i < 11; i++) begin
      entry = (i < log_q.size()) ? log_q[i] : 13'h1FFF;
      chk("b2b_entry", 32'(entry),
          32'({(i < 7) ? 2'd0 : 2'd3, (i < 7) ? 3'(i) : 3'(i - 7), 8'(8'h30 + i * 5)}));
    end

    // Stretched timing instance: two held writes, 9-cycle period
    we_exp   = 18'h0381C;
    busy_exp = 18'h1FEFF;
    ack_exp  = 18'h10080;
    b_req0 = 1'b1; b_addr0 = 3'd4; b_voice0 = 2'd2; b_data0 = 8'hC3;
    for (int i = 0; i < 18; i++) begin
      tick();
      chk("str_we", 32'(b_bus_we), 32'(we_exp[i]));
      chk("str_busy", 32'(b_busy), 32'(busy_exp[i]));
      chk("str_ack0", 32'(b_ack0), 32'(ack_exp[i]));
      if (i == 16) b_req0 = 1'b0;
    end
    chk("str_ack1", 32'(b_ack1), 32'd0);
    chk("str_fields", 32'({b_bus_voice, b_bus_addr, b_bus_data}), 32'h14C3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sid_write_arbiter.md
SID_WRITE_ARBITER -- requirements
Module: sid_write_arbiter

Interface
REQ-001 Parameter SETUP_CYC, default 1, number of cycles bus fields are valid with bus_we low before the strobe; legal range 1..15.
REQ-002 Parameter STROBE_CYC, default 1, number of cycles bus_we is held high; legal range 1..15.
REQ-003 Parameter HOLD_CYC, default 1, number of cycles bus fields stay valid with bus_we low after the strobe; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req0, req1  input  1 each  write request from requester 0 (host) and requester 1 (sequencer); held high until the matching ack.
REQ-007 addr0, addr1  input  3 each  register address for each requester.
REQ-008 voice0, voice1  input  2 each  voice select for each requester; 3 selects the filter bank.
REQ-009 data0, data1  input  8 each  register write data for each requester.
REQ-010 ack0, ack1  output  1 each  one-cycle pulse signalling that the requester's write has completed.
REQ-011 bus_addr  output  3, bus_voice  output  2, bus_data  output  8  the SID register port fields.
REQ-012 bus_we  output  1  write strobe; the top level maps it to ui_in[7].
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 grant_id  output  1  requester currently or most recently granted.

Function
REQ-015 The arbiter SHALL implement states IDLE, SETUP, STROBE, HOLD and DONE, using a single 4-bit phase counter.
REQ-016 In IDLE, with any req high at a clock edge, the arbiter SHALL grant one requester, latch its addr/voice/data into bus_addr/bus_voice/bus_data, set grant_id, and enter SETUP.
REQ-017 Arbitration SHALL work as follows:
- Only one req high: grant that requester.
- Both req high: grant the requester that was not granted last (round-robin).
- The last-grant bit resets so that requester 0 wins the first contention.
REQ-018 The arbiter SHALL remain in SETUP for exactly SETUP_CYC cycles with bus_we=0, then enter STROBE.
REQ-019 The arbiter SHALL remain in STROBE for exactly STROBE_CYC cycles with bus_we=1, then enter HOLD.
REQ-020 The arbiter SHALL remain in HOLD for exactly HOLD_CYC cycles with bus_we=0, then enter DONE.
REQ-021 DONE SHALL last one cycle, pulse ack of the granted requester only, perform no arbitration, and then return to IDLE.
REQ-022 bus_addr, bus_voice and bus_data SHALL be constant from SETUP through DONE.
- Changes to the requester's inputs after the grant are ignored.
- The fields retain their last value while in IDLE.
REQ-023 Timing with req sampled high in IDLE at edge E: bus_we rises at edge E+SETUP_CYC and the ack pulse occupies the cycle after edge E+SETUP_CYC+STROBE_CYC+HOLD_CYC.
REQ-024 One write SHALL occupy 2+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles including IDLE and DONE; this is 5 cycles with the default parameters.
REQ-025 A requester that keeps req high after its ack SHALL be treated as issuing a new write at the next IDLE arbitration.
REQ-026 A req that rises while busy SHALL wait; it is arbitrated in the next IDLE cycle and is never lost.
REQ-027 bus_we, ack0 and ack1 SHALL be driven from registers (glitch-free), and ack0 and ack1 SHALL never be high together.

Reset
REQ-028 While rst is high, asynchronously:
- state=IDLE and the phase counter is 0.
- bus_we, ack0, ack1, busy, grant_id and the last-grant bit are 0.
- bus_addr, bus_voice and bus_data are 0.
REQ-029 Reset asserted mid-write SHALL abort the write with no ack; a requester still holding req after reset is re-arbitrated normally.

Verification
REQ-030 Default parameters; req0 with addr=6, voice=0, data=0x21 → bus_we high for exactly 1 cycle, 2 cycles after req is sampled; fields read 6/0/0x21 from SETUP to DONE; ack0 pulses once on the 5th cycle; ack1 stays 0.
REQ-031 req0 and req1 raised in the same cycle after reset, both held and re-raised after each ack → grant order 0,1,0,1 over 4 writes; each strobe carries the payload of the granted requester.
REQ-032 data0 changed from 0x0F to 0xFF during STROBE → bus_data stays 0x0F through DONE.
REQ-033 rst pulsed during STROBE → bus_we falls without waiting for a clock edge; no ack is issued; after release, req0 (still held) is written with the full 5-cycle sequence.
REQ-034 SETUP_CYC=2, STROBE_CYC=3, HOLD_CYC=2 → bus_we is high for exactly 3 consecutive cycles; busy is high for 8 cycles per write; the write period is 9 cycles.
REQ-035 Eleven back-to-back req1 writes programming voice 0 and the filter bank (voice=3), followed by a bus-protocol checker → all 11 writes are observed in order, none dropped or duplicated, with bus_we never high in adjacent write windows.
